// File: rtl/stream_vec_acc.sv
`default_nettype none
// ============================================================================
// Module   : stream_vec_acc
// Purpose  : Joins the A/B/C stream2acc streams, computes a lane-wise
//            multiply-or-add (with optional bias) and accumulates it over
//            LEN beats. Each finished vector goes out on acc2stream_data_0.
//            Configuration and launch are done through a CSR req/rsp port.
// Ports    : clk_i/rst_i                - clock, synchronous active-high reset
//            stream2acc_data_0_*        - A operand stream (NUM_LANES lanes)
//            stream2acc_data_1_*        - B operand stream (NUM_LANES lanes)
//            stream2acc_data_2_*        - C bias stream, low lane used
//            acc2stream_data_0_*        - result vector stream
//            io_csr_req_* / io_csr_rsp_* - CSR request / read response
// Revision : 1.0 - initial release
// ============================================================================
module stream_vec_acc #(
    parameter int NUM_LANES  = 8,
    parameter int LANE_WIDTH = 32,
    parameter int BIAS_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_LANES*LANE_WIDTH-1:0] stream2acc_data_0_bits_i,
    input  logic                            stream2acc_data_0_valid_i,
    output logic                            stream2acc_data_0_ready_o,
    input  logic [NUM_LANES*LANE_WIDTH-1:0] stream2acc_data_1_bits_i,
    input  logic                            stream2acc_data_1_valid_i,
    output logic                            stream2acc_data_1_ready_o,
    input  logic [BIAS_WIDTH-1:0]           stream2acc_data_2_bits_i,
    input  logic                            stream2acc_data_2_valid_i,
    output logic                            stream2acc_data_2_ready_o,
    output logic [NUM_LANES*LANE_WIDTH-1:0] acc2stream_data_0_bits_o,
    output logic                            acc2stream_data_0_valid_o,
    input  logic                            acc2stream_data_0_ready_i,
    input  logic [31:0]                     io_csr_req_bits_data_i,
    input  logic [31:0]                     io_csr_req_bits_addr_i,
    input  logic                            io_csr_req_bits_write_i,
    input  logic                            io_csr_req_valid_i,
    output logic                            io_csr_req_ready_o,
    input  logic                            io_csr_rsp_ready_i,
    output logic                            io_csr_rsp_valid_o,
    output logic [31:0]                     io_csr_rsp_bits_data_o
);

    localparam int c_VEC_WIDTH = NUM_LANES * LANE_WIDTH;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic                   w_busy;
    logic                   w_in_run;

    logic [CNT_WIDTH-1:0]   r_len;
    logic [CNT_WIDTH-1:0]   r_num_out;
    logic [1:0]             r_mode;
    logic [CNT_WIDTH-1:0]   r_beat_cnt;
    logic [CNT_WIDTH-1:0]   r_out_cnt;
    logic [31:0]            r_cycles;

    logic                   r_rsp_valid;
    logic [31:0]            r_rsp_data;
    logic [31:0]            w_rd_data;

    logic [c_VEC_WIDTH-1:0] r_out_bits;
    logic                   r_out_valid;
    logic [c_VEC_WIDTH-1:0] w_acc_next_vec;

    logic w_req_ready, w_req_fire, w_wr, w_rd, w_start;
    logic w_last_beat, w_fire, w_last_fire, w_final_fire, w_out_release;

    // Upper C bits and upper CSR write-data bits carry no meaning here.
    logic w_unused_bits;
    assign w_unused_bits = ^{stream2acc_data_2_bits_i[BIAS_WIDTH-1:LANE_WIDTH],
                             io_csr_req_bits_data_i[31:CNT_WIDTH]};

    // ------------------------------------------------------------------
    // CSR handshake and decode
    // ------------------------------------------------------------------
    assign w_req_ready = !(r_rsp_valid && !io_csr_rsp_ready_i);
    assign w_req_fire  = io_csr_req_valid_i && w_req_ready;
    assign w_wr        = w_req_fire && io_csr_req_bits_write_i;
    assign w_rd        = w_req_fire && !io_csr_req_bits_write_i;
    assign w_start     = w_wr && (io_csr_req_bits_addr_i == 32'd3) && !w_busy &&
                         (r_len != '0) && (r_num_out != '0);

    // ------------------------------------------------------------------
    // Stream join. A last beat may only fire when the result register is
    // free or being released in the same cycle.
    // ------------------------------------------------------------------
    assign w_out_release = r_out_valid && acc2stream_data_0_ready_i;
    assign w_last_beat   = (r_beat_cnt == r_len - 1'b1);
    assign w_fire        = w_in_run && stream2acc_data_0_valid_i &&
                           stream2acc_data_1_valid_i && stream2acc_data_2_valid_i &&
                           !(w_last_beat && r_out_valid && !acc2stream_data_0_ready_i);
    assign w_last_fire   = w_fire && w_last_beat;
    assign w_final_fire  = w_last_fire && (r_out_cnt == r_num_out - 1'b1);

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_start)       w_state_next = c_ST_RUN;
            c_ST_RUN:   if (w_final_fire)  w_state_next = c_ST_DRAIN;
            c_ST_DRAIN: if (w_out_release) w_state_next = c_ST_IDLE;
            default:                       w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = (r_state != c_ST_IDLE);
        w_in_run = (r_state == c_ST_RUN);
    end

    // ------------------------------------------------------------------
    // Configuration registers (frozen while busy)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_len     <= '0;
            r_num_out <= '0;
            r_mode    <= '0;
        end else if (w_wr && !w_busy) begin
            case (io_csr_req_bits_addr_i)
                32'd0:   r_len     <= io_csr_req_bits_data_i[CNT_WIDTH-1:0];
                32'd1:   r_num_out <= io_csr_req_bits_data_i[CNT_WIDTH-1:0];
                32'd2:   r_mode    <= io_csr_req_bits_data_i[1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (io_csr_req_bits_addr_i)
            32'd0:   w_rd_data = 32'(r_len);
            32'd1:   w_rd_data = 32'(r_num_out);
            32'd2:   w_rd_data = 32'(r_mode);
            32'd4:   w_rd_data = (32'(r_out_cnt) << 16) | 32'(w_busy);
            32'd5:   w_rd_data = r_cycles;
            default: w_rd_data = '0;
        endcase
    end

    // Read response is held until taken; a new read can only be accepted
    // in the cycle the old one is consumed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else if (w_rd) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rd_data;
        end else if (io_csr_rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Beat / output / cycle counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i || w_start) begin
            r_beat_cnt <= '0;
            r_out_cnt  <= '0;
            r_cycles   <= '0;
        end else begin
            if (w_busy) begin
                r_cycles <= r_cycles + 32'd1;
            end
            if (w_fire) begin
                r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
            end
            if (w_last_fire) begin
                r_out_cnt <= r_out_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lane datapath
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [LANE_WIDTH-1:0] w_a, w_b, w_bias, w_term, w_acc_next;
        logic [LANE_WIDTH-1:0] r_acc;

        assign w_a        = stream2acc_data_0_bits_i[i*LANE_WIDTH +: LANE_WIDTH];
        assign w_b        = stream2acc_data_1_bits_i[i*LANE_WIDTH +: LANE_WIDTH];
        assign w_bias     = r_mode[1] ? stream2acc_data_2_bits_i[LANE_WIDTH-1:0] : '0;
        assign w_term     = (r_mode[0] ? (w_a + w_b) : (w_a * w_b)) + w_bias;
        assign w_acc_next = r_acc + w_term;

        assign w_acc_next_vec[i*LANE_WIDTH +: LANE_WIDTH] = w_acc_next;

        always_ff @(posedge clk_i) begin
            if (rst_i || w_start) begin
                r_acc <= '0;
            end else if (w_fire) begin
                r_acc <= w_last_beat ? '0 : w_acc_next;
            end
        end
    end

    // Result register: loads the same-cycle sum on the last beat, which may
    // coincide with the release of the previous result (no bubble).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_valid <= 1'b0;
            r_out_bits  <= '0;
        end else if (w_last_fire) begin
            r_out_valid <= 1'b1;
            r_out_bits  <= w_acc_next_vec;
        end else if (w_out_release) begin
            r_out_valid <= 1'b0;
        end
    end

    assign stream2acc_data_0_ready_o = w_fire;
    assign stream2acc_data_1_ready_o = w_fire;
    assign stream2acc_data_2_ready_o = w_fire;
    assign acc2stream_data_0_bits_o  = r_out_bits;
    assign acc2stream_data_0_valid_o = r_out_valid;
    assign io_csr_req_ready_o        = w_req_ready;
    assign io_csr_rsp_valid_o        = r_rsp_valid;
    assign io_csr_rsp_bits_data_o    = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_stream_vec_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_vec_acc
// Purpose  : Self-checking bench for stream_vec_acc. CSR table vectors,
//            directed multi-cycle sequences and randomized runs compared
//            against a lane-sum reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_vec_acc;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] a_bits = '0, b_bits = '0;
    logic [63:0]  c_bits = '0;
    logic         a_v = 1'b0, b_v = 1'b0, c_v = 1'b0;
    logic         a_r, b_r, c_r;
    logic [255:0] o_bits;
    logic         o_v;
    logic         o_r = 1'b0;
    logic [31:0]  csr_wdata = '0, csr_addr = '0;
    logic         csr_we = 1'b0, csr_v = 1'b0, rsp_rdy = 1'b1;
    logic         csr_rdy, rsp_v;
    logic [31:0]  rsp_data;

    always #5 clk = ~clk;

    stream_vec_acc dut (
        .clk_i                     (clk),
        .rst_i                     (rst),
        .stream2acc_data_0_bits_i  (a_bits),
        .stream2acc_data_0_valid_i (a_v),
        .stream2acc_data_0_ready_o (a_r),
        .stream2acc_data_1_bits_i  (b_bits),
        .stream2acc_data_1_valid_i (b_v),
        .stream2acc_data_1_ready_o (b_r),
        .stream2acc_data_2_bits_i  (c_bits),
        .stream2acc_data_2_valid_i (c_v),
        .stream2acc_data_2_ready_o (c_r),
        .acc2stream_data_0_bits_o  (o_bits),
        .acc2stream_data_0_valid_o (o_v),
        .acc2stream_data_0_ready_i (o_r),
        .io_csr_req_bits_data_i    (csr_wdata),
        .io_csr_req_bits_addr_i    (csr_addr),
        .io_csr_req_bits_write_i   (csr_we),
        .io_csr_req_valid_i        (csr_v),
        .io_csr_req_ready_o        (csr_rdy),
        .io_csr_rsp_ready_i        (rsp_rdy),
        .io_csr_rsp_valid_o        (rsp_v),
        .io_csr_rsp_bits_data_o    (rsp_data)
    );

    int vectors = 0;
    int miscompares = 0;
    bit aborted = 0;

    logic [255:0] mem_a [64];
    logic [255:0] mem_b [64];
    logic [63:0]  mem_c [64];
    logic [255:0] exp_res [16];
    int           j_len, j_nout, j_skew, j_hold;
    bit           j_rnd;
    logic [1:0]   j_mode;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          write;
        logic [31:0] exp;
    } csr_vec_t;
    csr_vec_t tbl [12];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic csr_write(input logic [31:0] addr, input logic [31:0] data);
        int n = 0;
        @(negedge clk);
        csr_addr = addr; csr_wdata = data; csr_we = 1'b1; csr_v = 1'b1;
        while (!csr_rdy && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        csr_v = 1'b0; csr_we = 1'b0;
    endtask

    task automatic csr_read(input logic [31:0] addr, output logic [31:0] data);
        int n = 0;
        @(negedge clk);
        csr_addr = addr; csr_we = 1'b0; csr_v = 1'b1; rsp_rdy = 1'b1;
        while (!csr_rdy && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        csr_v = 1'b0;
        check("rsp_latency", rsp_v, 1);
        data = rsp_data;
    endtask

    // Reference: every output lane is the mod-2^32 sum of its LEN per-beat terms.
    task automatic build_expected();
        for (int o = 0; o < j_nout; o++) begin
            for (int l = 0; l < 8; l++) begin
                longint unsigned s = 0;
                for (int k = 0; k < j_len; k++) begin
                    longint unsigned a, b, c, t;
                    a = longint'(mem_a[o*j_len+k][l*32 +: 32]);
                    b = longint'(mem_b[o*j_len+k][l*32 +: 32]);
                    c = longint'(mem_c[o*j_len+k][31:0]);
                    t = j_mode[0] ? (a + b) : (a * b);
                    if (j_mode[1]) t = t + c;
                    s = s + t;
                end
                exp_res[o][l*32 +: 32] = s[31:0];
            end
        end
    endtask

    task automatic drive_all();
        int total = j_len * j_nout;
        for (int k = 0; k < total; k++) begin
            int n = 0;
            @(negedge clk);
            if (j_rnd && $urandom_range(0, 3) == 0) begin
                a_v = 1'b0; b_v = 1'b0; c_v = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            a_bits = mem_a[k]; b_bits = mem_b[k]; c_bits = mem_c[k];
            a_v = 1'b1; b_v = 1'b1; c_v = 1'b1;
            if (k == 0 && j_skew > 0) begin
                b_v = 1'b0;
                for (int s = 0; s < j_skew; s++) begin
                    #2;
                    check("skew_ready", {a_r, b_r, c_r}, 0);
                    @(negedge clk);
                end
                b_v = 1'b1;
            end
            forever begin
                #2;
                if (a_r) break;
                n++;
                if (n > 200 || aborted) begin
                    check("beat_timeout", n, 0);
                    aborted = 1;
                    break;
                end
                @(negedge clk);
            end
            if (aborted) break;
            check("join_ready", {a_r, b_r, c_r}, 3'b111);
            @(posedge clk);
            if ((k % j_len) == j_len - 1) begin
                #1;
                check("result_latency", o_v, 1);
                check("result_load", o_bits, exp_res[k / j_len]);
            end
        end
        @(negedge clk);
        a_v = 1'b0; b_v = 1'b0; c_v = 1'b0;
    endtask

    task automatic consume_all();
        int got = 0;
        int cyc = 0;
        while (got < j_nout && !aborted) begin
            @(negedge clk);
            cyc++;
            if (cyc <= j_hold) o_r = 1'b0;
            else if (j_rnd)    o_r = ($urandom_range(0, 2) != 0);
            else               o_r = 1'b1;
            if (cyc <= j_hold && o_v) begin
                check("hold_bits", o_bits, exp_res[got]);
                if (j_len == 1) begin
                    #2;
                    check("stall_ready", a_r, 0);
                end
            end
            if (o_v && o_r) begin
                check("result", o_bits, exp_res[got]);
                got++;
            end
            if (cyc > 2000) begin
                check("result_timeout", got, j_nout);
                aborted = 1;
            end
        end
    endtask

    task automatic run_job(input int len, input int nout, input logic [1:0] mode,
                           input int skew, input int hold, input bit rnd);
        logic [31:0] d;
        j_len = len; j_nout = nout; j_mode = mode;
        j_skew = skew; j_hold = hold; j_rnd = rnd;
        build_expected();
        csr_write(0, len);
        csr_write(1, nout);
        csr_write(2, 32'(mode));
        csr_write(3, 1);
        fork
            drive_all();
            consume_all();
        join
        csr_read(4, d);
        check("status_done", d, 32'(nout) << 16);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;

        // Reset values
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {a_r, b_r, c_r}, 0);
        check("rst_out_valid", o_v, 0);
        check("rst_out_bits", o_bits, 0);
        check("rst_rsp_valid", rsp_v, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_req_ready", csr_rdy, 1);

        // CSR table
        tbl[0]  = '{32'd0, 32'd4, 1'b1, 32'd0};
        tbl[1]  = '{32'd1, 32'd2, 1'b1, 32'd0};
        tbl[2]  = '{32'd2, 32'd1, 1'b1, 32'd0};
        tbl[3]  = '{32'd0, 32'd0, 1'b0, 32'd4};
        tbl[4]  = '{32'd1, 32'd0, 1'b0, 32'd2};
        tbl[5]  = '{32'd2, 32'd0, 1'b0, 32'd1};
        tbl[6]  = '{32'd3, 32'd0, 1'b0, 32'd0};
        tbl[7]  = '{32'd4, 32'd0, 1'b0, 32'd0};
        tbl[8]  = '{32'd5, 32'd0, 1'b0, 32'd0};
        tbl[9]  = '{32'd9, 32'h1234, 1'b1, 32'd0};
        tbl[10] = '{32'd9, 32'd0, 1'b0, 32'd0};
        tbl[11] = '{32'd0, 32'd0, 1'b0, 32'd4};
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].write) csr_write(tbl[i].addr, tbl[i].data);
            else begin
                csr_read(tbl[i].addr, d);
                check($sformatf("csr_tbl_%0d", i), d, tbl[i].exp);
            end
        end

        // Add mode, no bias: (1+2)*2 beats = 6 per lane
        for (int k = 0; k < 2; k++) begin
            for (int l = 0; l < 8; l++) begin
                mem_a[k][l*32 +: 32] = 32'd1;
                mem_b[k][l*32 +: 32] = 32'd2;
            end
            mem_c[k] = 64'hFFFF_0000_0000_0099;
        end
        run_job(2, 1, 2'd1, 0, 0, 1'b0);
        check("add_lane_value", exp_res[0][31:0], 32'd6);

        // Mul with bias: lane i = 3i + 5
        for (int k = 0; k < 3; k++) begin
            for (int l = 0; l < 8; l++) begin
                mem_a[k][l*32 +: 32] = 32'(l);
                mem_b[k][l*32 +: 32] = 32'd3;
            end
            mem_c[k] = 64'd5;
        end
        run_job(1, 3, 2'd2, 0, 0, 1'b0);
        check("mul_bias_lane7", exp_res[2][255:224], 32'd26);
        csr_read(5, d);
        check("cycles_min", d >= 32'd3, 1);

        // Backpressure: result held 10 cycles, second last beat stalls
        for (int k = 0; k < 2; k++) begin
            for (int l = 0; l < 8; l++) begin
                mem_a[k][l*32 +: 32] = $urandom;
                mem_b[k][l*32 +: 32] = $urandom;
            end
            mem_c[k] = {$urandom, $urandom};
        end
        run_job(1, 2, 2'd0, 0, 10, 1'b0);

        // Join skew on B plus add wrap-around to 0
        for (int l = 0; l < 8; l++) begin
            mem_a[0][l*32 +: 32] = 32'hFFFF_FFFF;
            mem_b[0][l*32 +: 32] = 32'd1;
        end
        mem_c[0] = 64'd7;
        run_job(1, 1, 2'd1, 5, 0, 1'b0);
        check("wrap_lane0", exp_res[0][31:0], 32'd0);

        // Randomized runs
        for (int r = 0; r < 6 && !aborted; r++) begin
            int len = $urandom_range(1, 4);
            int nout = $urandom_range(1, 4);
            for (int k = 0; k < len * nout; k++) begin
                for (int l = 0; l < 8; l++) begin
                    mem_a[k][l*32 +: 32] = $urandom;
                    mem_b[k][l*32 +: 32] = $urandom;
                end
                mem_c[k] = {$urandom, $urandom};
            end
            run_job(len, nout, 2'($urandom_range(0, 3)), 0, 0, 1'b1);
        end

        // Illegal start: LEN == 0
        csr_write(0, 0);
        csr_write(3, 1);
        csr_read(4, d);
        check("start_len0_busy", d[0], 0);

        // Abort mid-run with a pending result
        csr_write(0, 1);
        csr_write(1, 4);
        csr_write(2, 1);
        csr_write(3, 1);
        @(negedge clk);
        o_r = 1'b0;
        a_bits = '1; b_bits = '1; c_bits = '0;
        a_v = 1'b1; b_v = 1'b1; c_v = 1'b1;
        repeat (3) @(negedge clk);
        check("pending_before_reset", o_v, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready", {a_r, b_r, c_r}, 0);
        check("abort_out_valid", o_v, 0);
        check("abort_out_bits", o_bits, 0);
        check("abort_rsp_valid", rsp_v, 0);
        check("abort_req_ready", csr_rdy, 1);
        rst = 1'b0;
        a_v = 1'b0; b_v = 1'b0; c_v = 1'b0;
        csr_read(4, d);
        check("abort_status", d, 0);
        csr_read(0, d);
        check("abort_len", d, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
